// File: rtl/spmv_row_accum_pkg.sv
// Shared widths, FSM encoding and row-pointer slice helper for the SpMV row accumulator.
// Pure declarations: no latency and no flow control of its own.
package spmv_pkg;
  localparam int N_ROWS = 16;
  localparam int PTR_W  = 8;
  localparam int IDX_W  = 4;
  localparam int VAL_W  = 16;
  localparam int ACC_W  = 40;
  localparam int N_VEC  = 2 ** IDX_W;
  localparam int ROW_W  = $clog2(N_ROWS);
  localparam int RIDX_W = $clog2(N_ROWS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef logic [PTR_W-1:0]            ptr_t;
  typedef logic [(N_ROWS+1)*PTR_W-1:0] ptr_bus_t;

  function automatic ptr_t row_ptr_at(input ptr_bus_t bus, input logic [RIDX_W-1:0] r);
    return bus[r*PTR_W +: PTR_W];
  endfunction
endpackage

// File: rtl/spmv_row_accum_if.sv
// CSR reader link, vector input and row-result outputs of the row accumulator.
// Wiring only; the reader answers o_count combinationally and nothing is back-pressured.
interface spmv_row_accum_if;
  import spmv_pkg::*;

  logic                    i_start;
  ptr_bus_t                i_row_ptr;
  logic [IDX_W-1:0]        i_col_idx;
  logic signed [VAL_W-1:0] i_val;
  logic [N_VEC*VAL_W-1:0]  i_vec;
  ptr_t                    o_count;
  logic                    o_busy;
  logic                    o_row_valid;
  logic [ROW_W-1:0]        o_row_idx;
  logic signed [ACC_W-1:0] o_row_sum;
  logic                    o_done;

  modport master (
    output i_start, i_row_ptr, i_col_idx, i_val, i_vec,
    input  o_count, o_busy, o_row_valid, o_row_idx, o_row_sum, o_done
  );

  modport slave (
    input  i_start, i_row_ptr, i_col_idx, i_val, i_vec,
    output o_count, o_busy, o_row_valid, o_row_idx, o_row_sum, o_done
  );
endinterface

// File: rtl/spmv_row_accum_mac.sv
// Signed VAL_W x VAL_W multiply, sign-extended into a wrapping ACC_W accumulator.
// One cycle per accumulate; clear and enable come from the row FSM, no back-pressure.
module spmv_mac
  import spmv_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic signed [VAL_W-1:0] val,
  input  logic signed [VAL_W-1:0] vec_elem,
  input  logic                    clear,
  input  logic                    en,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [2*VAL_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;

  assign prod     = val * vec_elem;
  assign prod_ext = {{(ACC_W-2*VAL_W){prod[2*VAL_W-1]}}, prod};

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end
endmodule

// File: rtl/spmv_row_accum.sv
// Walks CSR rows one nonzero per cycle and emits one signed sum per row.
// Row takes nnz+1 cycles, run ends N_ROWS+nnz+1 cycles after start; no back-pressure.
module spmv_row_accum
  import spmv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  spmv_row_accum_if.slave bus
);
  state_t                  state_q, state_d;
  ptr_bus_t                ptr_q;
  ptr_t                    count_q;
  ptr_t                    row_end;
  logic [ROW_W-1:0]        row_q;
  logic [RIDX_W-1:0]       row_nxt;
  logic                    load, emit, mac_clr, mac_en, last_row;
  logic signed [VAL_W-1:0] vec_elem;
  logic signed [ACC_W-1:0] acc;
  logic                    row_valid_q, done_q;
  logic [ROW_W-1:0]        row_idx_q;
  logic signed [ACC_W-1:0] row_sum_q;

  assign row_nxt  = {1'b0, row_q} + RIDX_W'(1);
  assign row_end  = row_ptr_at(ptr_q, row_nxt);
  assign last_row = (row_q == ROW_W'(N_ROWS - 1));
  assign vec_elem = bus.i_vec[bus.i_col_idx*VAL_W +: VAL_W];

  spmv_mac u_mac (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .val      (bus.i_val),
    .vec_elem (vec_elem),
    .clear    (mac_clr),
    .en       (mac_en),
    .acc      (acc)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    emit    = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          load    = 1'b1;
          mac_clr = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Unsigned >= also closes malformed rows whose end lies behind the cursor.
        if (count_q >= row_end) begin
          emit    = 1'b1;
          mac_clr = 1'b1;
          if (last_row) begin
            state_d = DONE;
          end
        end else begin
          mac_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      row_q       <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
      row_idx_q   <= '0;
      row_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_valid_q <= emit;
      done_q      <= emit && last_row;
      if (load) begin
        ptr_q   <= bus.i_row_ptr;
        count_q <= row_ptr_at(bus.i_row_ptr, '0);
        row_q   <= '0;
      end else if (emit) begin
        row_q <= row_q + ROW_W'(1);
      end else if (mac_en) begin
        count_q <= count_q + PTR_W'(1);
      end
      if (emit) begin
        row_idx_q <= row_q;
        row_sum_q <= acc;
      end
    end
  end

  assign bus.o_count     = count_q;
  assign bus.o_busy      = (state_q == SCAN);
  assign bus.o_row_valid = row_valid_q;
  assign bus.o_row_idx   = row_idx_q;
  assign bus.o_row_sum   = row_sum_q;
  assign bus.o_done      = done_q;
endmodule
